// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM stage: MMIO address map, write-back select codes and TCON bits.
`timescale 1ns/1ps
package mem_stage_pkg;

  localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
  localparam logic [31:0] ADDR_LEDS    = 32'h4000_000C;
  localparam logic [31:0] ADDR_DIGITS  = 32'h4000_0010;
  localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;

  typedef enum logic [1:0] {
    MTR_ALU  = 2'b00,
    MTR_MEM  = 2'b01,
    MTR_PC4  = 2'b10,
    MTR_ZERO = 2'b11
  } mtr_e;

  localparam int TCON_EN  = 0;
  localparam int TCON_IE  = 1;
  localparam int TCON_IRQ = 2;

  // Word-aligned match: the byte offset within the word is dropped by the caller.
  function automatic logic addr_hit(input logic [29:0] word, input logic [31:0] base);
    return {word, 2'b00} == base;
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Reloading 32-bit timer: TH reload value, TL counter, TCON {irq, irq_en, run}.
`timescale 1ns/1ps
module mmio_timer
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we_th,
  input  logic        i_we_tl,
  input  logic        i_we_tcon,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_th,
  output logic [31:0] o_tl,
  output logic [2:0]  o_tcon
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic        w_wrap;

  assign w_wrap = r_tcon[TCON_EN] && (r_tl == 32'hFFFF_FFFF);

  // A store to a register wins over the timer's own update of that register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_th   <= '0;
      r_tl   <= '0;
      r_tcon <= '0;
    end else begin
      if (i_we_th)
        r_th <= i_wdata;

      if (i_we_tl)
        r_tl <= i_wdata;
      else if (w_wrap)
        r_tl <= r_th;
      else if (r_tcon[TCON_EN])
        r_tl <= r_tl + 32'd1;

      if (i_we_tcon)
        r_tcon <= i_wdata[2:0];
      else if (w_wrap && r_tcon[TCON_IE])
        r_tcon[TCON_IRQ] <= 1'b1;
    end
  end

  assign o_th   = r_th;
  assign o_tl   = r_tl;
  assign o_tcon = r_tcon;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage (data RAM + MMIO) and MEM/WB register. Define MEM_STAGE_TIMER_EN to build the timer.
`timescale 1ns/1ps
module mem_wb_stage
  import mem_stage_pkg::*;
#(
  parameter int RAM_WORDS = 256,
  parameter int LED_BITS  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_MemRead,
  input  logic                i_MemWrite,
  input  logic [31:0]         i_WriteData,
  input  logic [31:0]         i_ALU_out,
  input  logic [4:0]          i_WriteAddr,
  input  logic [1:0]          i_MemtoReg,
  input  logic                i_RegWrite,
  input  logic [31:0]         i_PC_Plus_4,
  output logic [31:0]         o_Fwd_Data,
  output logic                o_RegWrite,
  output logic [4:0]          o_WriteAddr,
  output logic [31:0]         o_WriteBackData,
  output logic [LED_BITS-1:0] o_leds,
  output logic [11:0]         o_digits,
  output logic                o_irq
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]         r_ram [RAM_WORDS];
  logic [LED_BITS-1:0] r_leds;
  logic [11:0]         r_digits;
  logic [31:0]         r_systick;
  logic [31:0]         r_wb_data_p1;
  logic                r_wb_rw_p1;
  logic [4:0]          r_wb_addr_p1;

  logic [29:0]   w_word;
  logic [AW-1:0] w_ram_idx;
  logic          w_in_ram;
  logic          w_we;
  logic          w_hit_th, w_hit_tl, w_hit_tcon, w_hit_leds, w_hit_digits, w_hit_systick;
  logic [31:0]   w_th, w_tl;
  logic [2:0]    w_tcon;
  logic [31:0]   w_rdata;
  logic [31:0]   w_fwd;
  logic          w_unused_lo;

  assign w_word        = i_ALU_out[31:2];
  assign w_unused_lo   = ^i_ALU_out[1:0];
  assign w_ram_idx     = i_ALU_out[AW+1:2];
  assign w_in_ram      = (i_ALU_out[31:AW+2] == '0);
  // Stores presented while reset is high are discarded everywhere, RAM included.
  assign w_we          = i_MemWrite & ~reset;
  assign w_hit_th      = addr_hit(w_word, ADDR_TH);
  assign w_hit_tl      = addr_hit(w_word, ADDR_TL);
  assign w_hit_tcon    = addr_hit(w_word, ADDR_TCON);
  assign w_hit_leds    = addr_hit(w_word, ADDR_LEDS);
  assign w_hit_digits  = addr_hit(w_word, ADDR_DIGITS);
  assign w_hit_systick = addr_hit(w_word, ADDR_SYSTICK);

  always_ff @(posedge clk) begin
    if (w_we && w_in_ram)
      r_ram[w_ram_idx] <= i_WriteData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_leds    <= '0;
      r_digits  <= '0;
      r_systick <= '0;
    end else begin
      r_systick <= r_systick + 32'd1;
      if (w_we && w_hit_leds)
        r_leds <= i_WriteData[LED_BITS-1:0];
      if (w_we && w_hit_digits)
        r_digits <= i_WriteData[11:0];
    end
  end

`ifdef MEM_STAGE_TIMER_EN
  mmio_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_we_th   (w_we & w_hit_th),
    .i_we_tl   (w_we & w_hit_tl),
    .i_we_tcon (w_we & w_hit_tcon),
    .i_wdata   (i_WriteData),
    .o_th      (w_th),
    .o_tl      (w_tl),
    .o_tcon    (w_tcon)
  );
  assign o_irq = w_tcon[TCON_IRQ];
`else
  assign w_th   = '0;
  assign w_tl   = '0;
  assign w_tcon = '0;
  assign o_irq  = 1'b0;
`endif

  // Stage p0: combinational read, always the pre-edge contents.
  always_comb begin
    w_rdata = '0;
    if (i_MemRead) begin
      if (w_in_ram)           w_rdata = r_ram[w_ram_idx];
      else if (w_hit_th)      w_rdata = w_th;
      else if (w_hit_tl)      w_rdata = w_tl;
      else if (w_hit_tcon)    w_rdata = {29'd0, w_tcon};
      else if (w_hit_leds)    w_rdata = 32'(r_leds);
      else if (w_hit_digits)  w_rdata = {20'd0, r_digits};
      else if (w_hit_systick) w_rdata = r_systick;
    end
  end

  always_comb begin
    w_fwd = '0;
    case (i_MemtoReg)
      MTR_ALU:  w_fwd = i_ALU_out;
      MTR_MEM:  w_fwd = w_rdata;
      MTR_PC4:  w_fwd = i_PC_Plus_4;
      MTR_ZERO: w_fwd = '0;
      default:  w_fwd = '0;
    endcase
  end

  // Stage p1: MEM/WB register; r0 is never written back.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_data_p1 <= '0;
      r_wb_rw_p1   <= 1'b0;
      r_wb_addr_p1 <= '0;
    end else begin
      r_wb_data_p1 <= w_fwd;
      r_wb_rw_p1   <= i_RegWrite & (i_WriteAddr != 5'd0);
      r_wb_addr_p1 <= i_WriteAddr;
    end
  end

  assign o_Fwd_Data      = w_fwd;
  assign o_RegWrite      = r_wb_rw_p1;
  assign o_WriteAddr     = r_wb_addr_p1;
  assign o_WriteBackData = r_wb_data_p1;
  assign o_leds          = r_leds;
  assign o_digits        = r_digits;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_mem_wb_stage;

`ifdef MEM_STAGE_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i_MemRead, i_MemWrite, i_RegWrite;
  logic [31:0] i_WriteData, i_ALU_out, i_PC_Plus_4;
  logic [4:0]  i_WriteAddr;
  logic [1:0]  i_MemtoReg;
  logic [31:0] o_Fwd_Data, o_WriteBackData;
  logic        o_RegWrite, o_irq;
  logic [4:0]  o_WriteAddr;
  logic [7:0]  o_leds;
  logic [11:0] o_digits;

  always #5 clk = ~clk;

  mem_wb_stage #(.RAM_WORDS(256), .LED_BITS(8)) dut (
    .clk(clk), .reset(reset),
    .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite), .i_WriteData(i_WriteData),
    .i_ALU_out(i_ALU_out), .i_WriteAddr(i_WriteAddr), .i_MemtoReg(i_MemtoReg),
    .i_RegWrite(i_RegWrite), .i_PC_Plus_4(i_PC_Plus_4),
    .o_Fwd_Data(o_Fwd_Data), .o_RegWrite(o_RegWrite), .o_WriteAddr(o_WriteAddr),
    .o_WriteBackData(o_WriteBackData), .o_leds(o_leds), .o_digits(o_digits), .o_irq(o_irq)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state of the memory map and WB register.
  logic [31:0] m_ram [int];
  logic [31:0] m_th = 0, m_tl = 0, m_tick = 0, m_wb_data = 0;
  logic [2:0]  m_tcon = 0;
  logic [7:0]  m_leds = 0;
  logic [11:0] m_digits = 0;
  logic [4:0]  m_wb_addr = 0;
  logic        m_wb_rw = 0;
  bit          m_wb_known = 1'b1;
  bit          m_ready = 1'b0;

  function automatic bit m_read(output logic [31:0] v);
    logic [31:0] a;
    v = 32'd0;
    if (!i_MemRead) return 1'b1;
    a = i_ALU_out & 32'hFFFF_FFFC;
    if (a < 32'd1024) begin
      if (!m_ram.exists(int'(a >> 2))) return 1'b0;
      v = m_ram[int'(a >> 2)];
    end else begin
      case (a)
        32'h4000_0000: v = m_th;
        32'h4000_0004: v = m_tl;
        32'h4000_0008: v = {29'd0, m_tcon};
        32'h4000_000C: v = {24'd0, m_leds};
        32'h4000_0010: v = {20'd0, m_digits};
        32'h4000_0014: v = m_tick;
        default:       v = 32'd0;
      endcase
    end
    return 1'b1;
  endfunction

  function automatic bit m_fwd(output logic [31:0] v);
    logic [31:0] rd;
    bit known;
    known = m_read(rd);
    v = 32'd0;
    case (i_MemtoReg)
      2'b00: v = i_ALU_out;
      2'b01: begin v = rd; return known; end
      2'b10: v = i_PC_Plus_4;
      default: v = 32'd0;
    endcase
    return 1'b1;
  endfunction

  initial begin : model_update
    logic [31:0] f, a;
    bit k;
    forever begin
      @(posedge clk);
      k = m_fwd(f);
      if (reset) begin
        m_th = 0; m_tl = 0; m_tcon = 0; m_leds = 0; m_digits = 0; m_tick = 0;
        m_wb_data = 0; m_wb_rw = 0; m_wb_addr = 0; m_wb_known = 1'b1;
        m_ready = 1'b1;
      end else begin
        m_wb_known = k;
        m_wb_data  = f;
        m_wb_rw    = i_RegWrite && (i_WriteAddr != 5'd0);
        m_wb_addr  = i_WriteAddr;
        m_tick     = m_tick + 1;
        if (TIMER && m_tcon[0]) begin
          if (m_tl == 32'hFFFF_FFFF) begin
            m_tl = m_th;
            if (m_tcon[1]) m_tcon[2] = 1'b1;
          end else begin
            m_tl = m_tl + 1;
          end
        end
        if (i_MemWrite) begin
          a = i_ALU_out & 32'hFFFF_FFFC;
          if (a < 32'd1024) m_ram[int'(a >> 2)] = i_WriteData;
          else if (TIMER && a == 32'h4000_0000) m_th = i_WriteData;
          else if (TIMER && a == 32'h4000_0004) m_tl = i_WriteData;
          else if (TIMER && a == 32'h4000_0008) m_tcon = i_WriteData[2:0];
          else if (a == 32'h4000_000C) m_leds = i_WriteData[7:0];
          else if (a == 32'h4000_0010) m_digits = i_WriteData[11:0];
        end
      end
    end
  end

  initial begin : compare
    logic [31:0] f;
    bit k;
    forever begin
      @(negedge clk);
      if (m_ready) begin
        k = m_fwd(f);
        if (k) chk("fwd", o_Fwd_Data, f);
        if (m_wb_known) chk("wb_data", o_WriteBackData, m_wb_data);
        chk("wb_rw", {31'd0, o_RegWrite}, {31'd0, m_wb_rw});
        chk("wb_addr", {27'd0, o_WriteAddr}, {27'd0, m_wb_addr});
        chk("leds", {24'd0, o_leds}, {24'd0, m_leds});
        chk("digits", {20'd0, o_digits}, {20'd0, m_digits});
        chk("irq", {31'd0, o_irq}, {31'd0, m_tcon[2]});
      end
    end
  end

  task automatic drv(input bit mr, input bit mw, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [1:0] mtr, input bit rw, input logic [4:0] wa, input logic [31:0] pc4);
    i_MemRead = mr; i_MemWrite = mw; i_ALU_out = addr; i_WriteData = wd;
    i_MemtoReg = mtr; i_RegWrite = rw; i_WriteAddr = wa; i_PC_Plus_4 = pc4;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drv(0, 0, 32'd0, 32'd0, 2'b00, 0, 5'd0, 32'd0);
  endtask

  task automatic st(input logic [31:0] addr, input logic [31:0] wd);
    drv(0, 1, addr, wd, 2'b00, 0, 5'd0, 32'd0);
  endtask

  task automatic ld(input logic [31:0] addr, input logic [4:0] wa);
    drv(1, 0, addr, 32'd0, 2'b01, 1, wa, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_wb_data", o_WriteBackData, 32'd0);
    chk("rst_wb_rw", {31'd0, o_RegWrite}, 32'd0);
    chk("rst_leds", {24'd0, o_leds}, 32'd0);
    chk("rst_irq", {31'd0, o_irq}, 32'd0);
    step();

    // Store then load, write-back one cycle later
    st(32'h10, 32'hDEAD_BEEF); step();
    ld(32'h10, 5'd8);
    @(negedge clk); chk("t1_fwd", o_Fwd_Data, 32'hDEAD_BEEF);
    step(); idle();
    @(negedge clk);
    chk("t1_wb_data", o_WriteBackData, 32'hDEAD_BEEF);
    chk("t1_wb_addr", {27'd0, o_WriteAddr}, 32'd8);
    chk("t1_wb_rw", {31'd0, o_RegWrite}, 32'd1);
    step();

    // Link value select
    drv(0, 0, 32'h1234, 32'd0, 2'b10, 1, 5'd31, 32'h0040_0024);
    @(negedge clk); chk("t2_fwd", o_Fwd_Data, 32'h0040_0024);
    step(); idle();
    @(negedge clk); chk("t2_wb", o_WriteBackData, 32'h0040_0024);
    step();

    // r0 destination suppresses RegWrite; zero select; MemRead low gives zero data
    drv(0, 0, 32'h77, 32'd0, 2'b00, 1, 5'd0, 32'd0); step(); idle();
    @(negedge clk);
    chk("r0_rw", {31'd0, o_RegWrite}, 32'd0);
    chk("r0_data", o_WriteBackData, 32'h77);
    drv(1, 0, 32'h10, 32'd0, 2'b11, 1, 5'd3, 32'h99);
    @(negedge clk); chk("mtr_zero", o_Fwd_Data, 32'd0);
    step();
    drv(0, 0, 32'h10, 32'd0, 2'b01, 1, 5'd3, 32'd0);
    @(negedge clk); chk("no_memread", o_Fwd_Data, 32'd0);
    step();

    // Same-cycle load and store return old data
    drv(1, 1, 32'h13, 32'h1111_1111, 2'b01, 1, 5'd4, 32'd0);
    @(negedge clk); chk("rw_old", o_Fwd_Data, 32'hDEAD_BEEF);
    step();
    ld(32'h10, 5'd4);
    @(negedge clk); chk("rw_new", o_Fwd_Data, 32'h1111_1111);
    step();

    // MMIO: LEDs, digits, unmapped, systick store ignored
    st(32'h4000_000C, 32'h0000_00A5); step(); idle();
    @(negedge clk); chk("t4_leds", {24'd0, o_leds}, 32'hA5);
    st(32'h4000_0010, 32'hFFFF_FF3C); step(); idle();
    @(negedge clk); chk("t4_digits", {20'd0, o_digits}, 32'hF3C);
    ld(32'h4000_0100, 5'd5);
    @(negedge clk); chk("t4_unmapped", o_Fwd_Data, 32'd0);
    step();
    st(32'h4000_0014, 32'd0); step();
    ld(32'h4000_0014, 5'd6); step();
    ld(32'h4000_0014, 5'd6); step();

    if (TIMER) begin
      st(32'h4000_0000, 32'hFFFF_FFFE); step();
      st(32'h4000_0004, 32'hFFFF_FFFE); step();
      st(32'h4000_0008, 32'd3); step();
      idle(); step();
      idle(); step();
      ld(32'h4000_0004, 5'd7);
      @(negedge clk);
      chk("t3_tl_reload", o_Fwd_Data, 32'hFFFF_FFFE);
      chk("t3_irq_set", {31'd0, o_irq}, 32'd1);
      step();
      ld(32'h4000_0008, 5'd7);
      @(negedge clk); chk("t3_tcon", o_Fwd_Data, 32'd7);
      step();
      st(32'h4000_0008, 32'd3); step(); idle();
      @(negedge clk); chk("t3_irq_clr", {31'd0, o_irq}, 32'd0);
      st(32'h4000_0004, 32'd5); step();
      ld(32'h4000_0004, 5'd7);
      @(negedge clk); chk("t3_tl_store_wins", o_Fwd_Data, 32'd5);
      step();
      ld(32'h4000_0004, 5'd7);
      @(negedge clk); chk("t3_tl_count", o_Fwd_Data, 32'd6);
      step();
      st(32'h4000_0008, 32'd0); step();
    end else begin
      st(32'h4000_0008, 32'd3); step();
      idle(); step();
      ld(32'h4000_0008, 5'd7);
      @(negedge clk);
      chk("t6_tcon", o_Fwd_Data, 32'd0);
      chk("t6_irq", {31'd0, o_irq}, 32'd0);
      step();
    end

    // Reset drops a concurrent store; RAM keeps prior contents
    st(32'h20, 32'h5555_AAAA); step();
    reset = 1'b1;
    drv(1, 1, 32'h20, 32'h1234, 2'b01, 1, 5'd9, 32'd0);
    step();
    reset = 1'b0;
    idle();
    @(negedge clk);
    chk("t5_wb_data", o_WriteBackData, 32'd0);
    chk("t5_wb_rw", {31'd0, o_RegWrite}, 32'd0);
    chk("t5_wb_addr", {27'd0, o_WriteAddr}, 32'd0);
    chk("t5_leds", {24'd0, o_leds}, 32'd0);
    chk("t5_digits", {20'd0, o_digits}, 32'd0);
    chk("t5_irq", {31'd0, o_irq}, 32'd0);
    step();
    ld(32'h20, 5'd10);
    @(negedge clk); chk("t5_ram_kept", o_Fwd_Data, 32'h5555_AAAA);
    step();
    ld(32'h4000_0014, 5'd10); step();
    idle(); step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
